simd_decode_stage: RTL and testbench
====================================

// Module: simd_decode_stage
// PURPOSE
//  Parametrised, pipelined SIMD instruction decoder with valid/ready handshake on both sides.
//  Sits between fetch and the per-thread register file/ALU/LSU in each core.
//  Adds over the single-cycle decoder: generic field widths, a 2-entry skid buffer,
//  CMP/BRNZP/NOP decode, illegal-opcode flagging, and pipeline flush.
// PARAMETERS
//  INSTRUCTION_WIDTH  32  instruction word width
//  OPCODE_WIDTH       6   opcode field, instr[IW-1 -: OPCODE_WIDTH]
//  REG_ADDR_WIDTH     7   width of each of rd, rm, rn
//  IMM_WIDTH          IW-OPCODE_WIDTH-REG_ADDR_WIDTH (derived, 19 by default) = {rm,rn,other}
//  NZP_WIDTH          3   branch condition mask, taken from rd[REG_ADDR_WIDTH-1 -: 3]
// PORTS
//  clk           in   1    clock
//  rst           in   1    synchronous, active-high reset
//  flush         in   1    drop all buffered instructions (branch redirect)
//  in_valid      in   1    instruction valid from fetch
//  in_ready      out  1    decoder can accept instruction this cycle
//  instruction   in   IW   instruction word
//  in_pc         in   8    PC of instruction, passed through
//  out_valid     out  1    decoded bundle valid
//  out_ready     in   1    downstream consumes bundle
//  out_pc        out  8    PC of bundle
//  reg_write     out  1    write rd
//  mem_read      out  1    LOAD
//  mem_write     out  1    STORE
//  reg_write_mux out  2    `REG_WRITE_LOAD/_ALU/_IMM
//  alu_op        out  3    `ALU_* code
//  nzp_write     out  1    CMP: update NZP flags
//  branch        out  1    BRNZP
//  nzp_mask      out  NZP  BRNZP condition mask
//  ret           out  1    RET
//  illegal       out  1    opcode not in table
//  rd, rm, rn    out  REG  register fields
//  imm           out  IMM  immediate (CONST, BRNZP target in low bits)
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1 on the next cycle, every control output and field = 0; skid buffer empty.
//  - Handshake: transfer when valid&&ready on the same edge. out_valid never drops until out_ready.
//    A held bundle stays bit-stable.
//  - Latency: 1 cycle; an instruction accepted at edge N is visible at out_* after edge N.
//    Full throughput 1/cycle while out_ready=1.
//  - Decode is combinational from the instruction word; the result is registered into a 2-entry buffer
//    (output reg + skid reg). in_ready = !skid_full (registered, no comb path from out_ready).
//    When out stalls, the next accepted bundle goes to the skid buffer.
//    When out is consumed, the skid entry moves to out the same edge.
//  - Decode table: all control bits default 0 per instruction.
//    LOAD: reg_write, mem_read, mux=LOAD.
//    STORE: mem_write=1.
//    ADD/SUB/MUL/DIV/AND/ORR: reg_write, alu_op, mux=ALU.
//    CONST: reg_write, mux=IMM, imm={rm,rn,other}.
//    CMP: nzp_write, alu_op=`ALU_SUB.
//    BRNZP: branch, nzp_mask.
//    RET: ret.
//    NOP: none.
//    Other opcodes: illegal=1 only.
//  - Fields rd/rm/rn/imm are always extracted, whatever the opcode.
//  - Simultaneous: in accept and out consume on one edge with skid empty: output replaced, skid stays empty.
//  - Full (both entries valid): in_ready=0; in_valid is ignored.
//  - flush: at the next edge, both entries are invalidated and the same-cycle input is not accepted.
//    Flush has priority over all handshakes. out_valid=0 and in_ready=1 after that edge.
//  - rst during a stall: same as flush, and all outputs are zeroed.
// STRUCTURE
//  - Opcodes `OP_CMP, `OP_BRNZP, `OP_NOP and the existing `OP_*/`ALU_*/`REG_WRITE_* live in common_defs.v.
//  - A decoded-bundle width define also lives in common_defs.v.
//  - Sub-module simd_skid_buffer #(WIDTH): a generic 2-entry valid/ready register slice holding
//    {pc, controls, fields}. The decode logic is a combinational function in the top.
// TESTING
//  1. rst=1 for 2 cycles -> out_valid=0, in_ready=1, all outputs 0.
//  2. ADD rd=5 rm=1 rn=2 with out_ready=1 -> next cycle out_valid=1, reg_write=1, alu_op=`ALU_ADD,
//     mux=ALU, rd=5, rm=1, rn=2.
//  3. CONST rd=3 imm=19'h12345 -> reg_write=1, mux=IMM, imm=19'h12345; then opcode 6'h3F -> illegal=1,
//     all other control bits 0.
//  4. out_ready=0, stream 3 instructions back to back -> first two accepted, in_ready=0 on the third;
//     release out_ready -> bundles emerge in order with no loss or duplicate.
//  5. Skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1;
//     the flushed-cycle instruction never appears.
//  6. BRNZP nzp=3'b010 target 8'h40, then CMP -> branch=1, nzp_mask=3'b010, imm[7:0]=8'h40;
//     then nzp_write=1, alu_op=`ALU_SUB, reg_write=0.

Source files
------------

// File: rtl/simd_decode_stage_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simd_decode_stage_pkg : opcode, ALU and write-back encodings for the decoder
// Rev 1.0
// ----------------------------------------------------------------------------
package simd_decode_stage_pkg;

   localparam int unsigned c_OP_NOP   = 0;
   localparam int unsigned c_OP_BRNZP = 1;
   localparam int unsigned c_OP_CMP   = 2;
   localparam int unsigned c_OP_ADD   = 3;
   localparam int unsigned c_OP_SUB   = 4;
   localparam int unsigned c_OP_MUL   = 5;
   localparam int unsigned c_OP_DIV   = 6;
   localparam int unsigned c_OP_LOAD  = 7;
   localparam int unsigned c_OP_STORE = 8;
   localparam int unsigned c_OP_CONST = 9;
   localparam int unsigned c_OP_AND   = 10;
   localparam int unsigned c_OP_ORR   = 11;
   localparam int unsigned c_OP_RET   = 15;

   localparam logic [2:0] c_ALU_ADD = 3'd0;
   localparam logic [2:0] c_ALU_SUB = 3'd1;
   localparam logic [2:0] c_ALU_MUL = 3'd2;
   localparam logic [2:0] c_ALU_DIV = 3'd3;
   localparam logic [2:0] c_ALU_AND = 3'd4;
   localparam logic [2:0] c_ALU_ORR = 3'd5;

   localparam logic [1:0] c_REG_WRITE_ALU  = 2'd0;
   localparam logic [1:0] c_REG_WRITE_LOAD = 2'd1;
   localparam logic [1:0] c_REG_WRITE_IMM  = 2'd2;

   localparam int unsigned c_PC_WIDTH = 8;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] reg_write_mux;
      logic [2:0] alu_op;
      logic       nzp_write;
      logic       branch;
      logic       ret;
      logic       illegal;
   } ctrl_t;

   localparam int unsigned c_CTRL_WIDTH = $bits(ctrl_t);

endpackage
`default_nettype wire

// File: rtl/simd_skid_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simd_skid_buffer : 2-entry valid/ready register slice (output reg + skid reg)
// Rev 1.0
// ----------------------------------------------------------------------------
module simd_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             out_valid_q, out_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             w_accept;
   logic             w_consume;

   // Ready depends only on skid occupancy, so there is no path from out_ready.
   assign in_ready  = !skid_valid_q;
   assign w_accept  = in_valid && !skid_valid_q;
   assign w_consume = out_valid_q && out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_data_d   = out_data_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || w_consume) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = w_accept;
            if (w_accept) begin
               out_data_d = in_data;
            end
         end
      end else if (w_accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_data_q   <= '0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_data_q   <= out_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: rtl/simd_decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simd_decode_stage : pipelined SIMD decoder with valid/ready on both sides
// Rev 1.0
// ----------------------------------------------------------------------------
module simd_decode_stage
   import simd_decode_stage_pkg::*;
#(
   parameter  int INSTRUCTION_WIDTH = 32,
   parameter  int OPCODE_WIDTH      = 6,
   parameter  int REG_ADDR_WIDTH    = 7,
   parameter  int NZP_WIDTH         = 3,
   localparam int IMM_WIDTH         = INSTRUCTION_WIDTH - OPCODE_WIDTH - REG_ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction,
   input  logic [7:0]                   in_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [7:0]                   out_pc,
   output logic                         reg_write,
   output logic                         mem_read,
   output logic                         mem_write,
   output logic [1:0]                   reg_write_mux,
   output logic [2:0]                   alu_op,
   output logic                         nzp_write,
   output logic                         branch,
   output logic [NZP_WIDTH-1:0]         nzp_mask,
   output logic                         ret,
   output logic                         illegal,
   output logic [REG_ADDR_WIDTH-1:0]    rd,
   output logic [REG_ADDR_WIDTH-1:0]    rm,
   output logic [REG_ADDR_WIDTH-1:0]    rn,
   output logic [IMM_WIDTH-1:0]         imm
);

   localparam int c_BUNDLE_WIDTH = c_PC_WIDTH + c_CTRL_WIDTH + NZP_WIDTH
                                   + 3 * REG_ADDR_WIDTH + IMM_WIDTH;

   function automatic ctrl_t decode(input logic [OPCODE_WIDTH-1:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OPCODE_WIDTH'(c_OP_LOAD): begin
            c.reg_write = 1'b1; c.mem_read = 1'b1; c.reg_write_mux = c_REG_WRITE_LOAD;
         end
         OPCODE_WIDTH'(c_OP_STORE): c.mem_write = 1'b1;
         OPCODE_WIDTH'(c_OP_ADD): begin
            c.reg_write = 1'b1; c.alu_op = c_ALU_ADD; c.reg_write_mux = c_REG_WRITE_ALU;
         end
         OPCODE_WIDTH'(c_OP_SUB): begin
            c.reg_write = 1'b1; c.alu_op = c_ALU_SUB; c.reg_write_mux = c_REG_WRITE_ALU;
         end
         OPCODE_WIDTH'(c_OP_MUL): begin
            c.reg_write = 1'b1; c.alu_op = c_ALU_MUL; c.reg_write_mux = c_REG_WRITE_ALU;
         end
         OPCODE_WIDTH'(c_OP_DIV): begin
            c.reg_write = 1'b1; c.alu_op = c_ALU_DIV; c.reg_write_mux = c_REG_WRITE_ALU;
         end
         OPCODE_WIDTH'(c_OP_AND): begin
            c.reg_write = 1'b1; c.alu_op = c_ALU_AND; c.reg_write_mux = c_REG_WRITE_ALU;
         end
         OPCODE_WIDTH'(c_OP_ORR): begin
            c.reg_write = 1'b1; c.alu_op = c_ALU_ORR; c.reg_write_mux = c_REG_WRITE_ALU;
         end
         OPCODE_WIDTH'(c_OP_CONST): begin
            c.reg_write = 1'b1; c.reg_write_mux = c_REG_WRITE_IMM;
         end
         OPCODE_WIDTH'(c_OP_CMP): begin
            c.nzp_write = 1'b1; c.alu_op = c_ALU_SUB;
         end
         OPCODE_WIDTH'(c_OP_BRNZP): c.branch = 1'b1;
         OPCODE_WIDTH'(c_OP_RET):   c.ret = 1'b1;
         OPCODE_WIDTH'(c_OP_NOP):   begin end
         default:                   c.illegal = 1'b1;
      endcase
      return c;
   endfunction

   logic [OPCODE_WIDTH-1:0]   w_opcode;
   ctrl_t                     w_ctrl;
   logic [NZP_WIDTH-1:0]      w_nzp;
   logic [REG_ADDR_WIDTH-1:0] w_rd, w_rm, w_rn;
   logic [IMM_WIDTH-1:0]      w_imm;
   logic [c_BUNDLE_WIDTH-1:0] w_in_data;
   logic [c_BUNDLE_WIDTH-1:0] w_out_data;
   ctrl_t                     w_out_ctrl;

   // The immediate overlaps rm/rn/other, so it is just the low field of the word.
   assign w_opcode = instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
   assign w_rd     = instruction[IMM_WIDTH+REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
   assign w_rm     = instruction[IMM_WIDTH-1 -: REG_ADDR_WIDTH];
   assign w_rn     = instruction[IMM_WIDTH-REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
   assign w_imm    = instruction[IMM_WIDTH-1:0];
   assign w_ctrl   = decode(w_opcode);
   assign w_nzp    = w_ctrl.branch ? w_rd[REG_ADDR_WIDTH-1 -: NZP_WIDTH] : '0;

   assign w_in_data = {in_pc, w_ctrl, w_nzp, w_rd, w_rm, w_rn, w_imm};

   simd_skid_buffer #(
      .WIDTH (c_BUNDLE_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (w_in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (w_out_data)
   );

   assign {out_pc, w_out_ctrl, nzp_mask, rd, rm, rn, imm} = w_out_data;

   assign reg_write     = w_out_ctrl.reg_write;
   assign mem_read      = w_out_ctrl.mem_read;
   assign mem_write     = w_out_ctrl.mem_write;
   assign reg_write_mux = w_out_ctrl.reg_write_mux;
   assign alu_op        = w_out_ctrl.alu_op;
   assign nzp_write     = w_out_ctrl.nzp_write;
   assign branch        = w_out_ctrl.branch;
   assign ret           = w_out_ctrl.ret;
   assign illegal       = w_out_ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_simd_decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_simd_decode_stage : directed vectors against a queue-based decoder model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_simd_decode_stage;
   import simd_decode_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] instruction;
   logic [7:0]  in_pc, out_pc;
   logic        reg_write, mem_read, mem_write, nzp_write, branch, ret, illegal;
   logic [1:0]  reg_write_mux;
   logic [2:0]  alu_op, nzp_mask;
   logic [6:0]  rd, rm, rn;
   logic [18:0] imm;

   always #5 clk = ~clk;

   simd_decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write_mux(reg_write_mux), .alu_op(alu_op), .nzp_write(nzp_write),
      .branch(branch), .nzp_mask(nzp_mask), .ret(ret), .illegal(illegal),
      .rd(rd), .rm(rm), .rn(rn), .imm(imm)
   );

   typedef struct packed {
      logic [7:0]  pc;
      logic        rw, mr, mw;
      logic [1:0]  mux;
      logic [2:0]  alu;
      logic        nw, br;
      logic [2:0]  nzp;
      logic        rt, il;
      logic [6:0]  rd, rm, rn;
      logic [18:0] imm;
   } exp_t;

   logic [62:0] dut_bundle;
   assign dut_bundle = {out_pc, reg_write, mem_read, mem_write, reg_write_mux, alu_op,
                        nzp_write, branch, nzp_mask, ret, illegal, rd, rm, rn, imm};

   int   errors = 0;
   int   checks = 0;
   bit   started = 1'b0;
   exp_t model_q[$];
   int   msz;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [31:0] mk(input int op, input logic [6:0] d, input logic [18:0] low);
      logic [5:0] o;
      o = 6'(op);
      return {o, d, low};
   endfunction

   // What the decoded bundle must contain for one accepted instruction.
   function automatic exp_t exp_of(input logic [31:0] ins, input logic [7:0] pc);
      exp_t e;
      int   op;
      e     = '0;
      op    = int'(ins[31:26]);
      e.pc  = pc;
      e.rd  = ins[25:19];
      e.rm  = ins[18:12];
      e.rn  = ins[11:5];
      e.imm = ins[18:0];
      if (op == c_OP_LOAD) begin e.rw = 1; e.mr = 1; e.mux = c_REG_WRITE_LOAD; end
      else if (op == c_OP_STORE) e.mw = 1;
      else if (op == c_OP_ADD) begin e.rw = 1; e.alu = c_ALU_ADD; e.mux = c_REG_WRITE_ALU; end
      else if (op == c_OP_SUB) begin e.rw = 1; e.alu = c_ALU_SUB; e.mux = c_REG_WRITE_ALU; end
      else if (op == c_OP_MUL) begin e.rw = 1; e.alu = c_ALU_MUL; e.mux = c_REG_WRITE_ALU; end
      else if (op == c_OP_DIV) begin e.rw = 1; e.alu = c_ALU_DIV; e.mux = c_REG_WRITE_ALU; end
      else if (op == c_OP_AND) begin e.rw = 1; e.alu = c_ALU_AND; e.mux = c_REG_WRITE_ALU; end
      else if (op == c_OP_ORR) begin e.rw = 1; e.alu = c_ALU_ORR; e.mux = c_REG_WRITE_ALU; end
      else if (op == c_OP_CONST) begin e.rw = 1; e.mux = c_REG_WRITE_IMM; end
      else if (op == c_OP_CMP) begin e.nw = 1; e.alu = c_ALU_SUB; end
      else if (op == c_OP_BRNZP) begin e.br = 1; e.nzp = ins[25:23]; end
      else if (op == c_OP_RET) e.rt = 1;
      else if (op != c_OP_NOP) e.il = 1;
      return e;
   endfunction

   // Model: an in-order queue of at most two decoded bundles.
   always @(posedge clk) begin
      msz = model_q.size();
      if (rst || flush) begin
         model_q.delete();
      end else begin
         if (out_ready && msz > 0) void'(model_q.pop_front());
         if (in_valid && msz < 2) model_q.push_back(exp_of(instruction, in_pc));
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
         check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
         if (model_q.size() != 0 && out_valid)
            check("bundle", 64'(dut_bundle), 64'(model_q[0]));
      end
   end

   logic [31:0] prog [9];
   int          idx;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instruction = '0; in_pc = '0;
      prog[0] = mk(c_OP_LOAD,  7'd9,  19'h0ABCD);
      prog[1] = mk(c_OP_STORE, 7'd2,  19'h12021);
      prog[2] = mk(c_OP_SUB,   7'd10, 19'h03045);
      prog[3] = mk(c_OP_MUL,   7'd11, 19'h05067);
      prog[4] = mk(c_OP_DIV,   7'd12, 19'h7FFFF);
      prog[5] = mk(c_OP_AND,   7'd13, 19'h00001);
      prog[6] = mk(c_OP_ORR,   7'h7F, 19'h40000);
      prog[7] = mk(c_OP_RET,   7'd0,  19'h00000);
      prog[8] = mk(c_OP_NOP,   7'd5,  19'h11111);

      repeat (2) @(negedge clk);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_outputs", 64'(dut_bundle), 64'd0);
      started = 1'b1;

      // ADD rd=5 rm=1 rn=2
      rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_pc = 8'h10;
      instruction = mk(c_OP_ADD, 7'd5, {7'd1, 7'd2, 5'd0});
      @(negedge clk);
      check("add_valid", 64'(out_valid), 64'd1);
      check("add_ctrl", 64'({reg_write, alu_op, reg_write_mux}), 64'({1'b1, c_ALU_ADD, c_REG_WRITE_ALU}));
      check("add_regs", 64'({out_pc, rd, rm, rn}), 64'({8'h10, 7'd5, 7'd1, 7'd2}));

      instruction = mk(c_OP_CONST, 7'd3, 19'h12345); in_pc = 8'h11;
      @(negedge clk);
      check("const_ctrl", 64'({reg_write, reg_write_mux}), 64'({1'b1, c_REG_WRITE_IMM}));
      check("const_imm", 64'({rd, imm}), 64'({7'd3, 19'h12345}));

      instruction = mk(6'h3F, 7'h55, 19'h2AAAA); in_pc = 8'h12;
      @(negedge clk);
      check("illegal_flag", 64'(illegal), 64'd1);
      check("illegal_others", 64'({reg_write, mem_read, mem_write, reg_write_mux, alu_op,
                                   nzp_write, branch, nzp_mask, ret}), 64'd0);
      in_valid = 1'b0;
      @(negedge clk);

      // Back-pressure: two accepted, third held off until the output drains.
      out_ready = 1'b0; in_valid = 1'b1;
      instruction = mk(c_OP_SUB, 7'd1, 19'h00100); in_pc = 8'h30;
      @(negedge clk);
      instruction = mk(c_OP_MUL, 7'd2, 19'h00200); in_pc = 8'h31;
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      instruction = mk(c_OP_DIV, 7'd3, 19'h00300); in_pc = 8'h32;
      @(negedge clk);
      check("stall_hold_pc", 64'(out_pc), 64'h30);
      out_ready = 1'b1;
      @(negedge clk);
      check("drain_pc1", 64'({out_pc, in_ready}), 64'({8'h31, 1'b1}));
      @(negedge clk);
      check("drain_pc2", 64'(out_pc), 64'h32);
      in_valid = 1'b0;
      @(negedge clk);
      check("drain_empty", 64'(out_valid), 64'd0);

      // Flush with both entries full and a live input.
      out_ready = 1'b0; in_valid = 1'b1;
      instruction = mk(c_OP_ADD, 7'd4, 19'h0); in_pc = 8'h40;
      @(negedge clk);
      instruction = mk(c_OP_SUB, 7'd4, 19'h0); in_pc = 8'h41;
      @(negedge clk);
      instruction = mk(c_OP_MUL, 7'd4, 19'h0); in_pc = 8'h42; flush = 1'b1;
      @(negedge clk);
      check("flush_state", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("flush_no_leak", 64'(out_valid), 64'd0);

      // BRNZP nzp=010 target 0x40, then CMP.
      in_valid = 1'b1; in_pc = 8'h50;
      instruction = mk(c_OP_BRNZP, 7'b010_0000, 19'h00040);
      @(negedge clk);
      check("brnzp", 64'({branch, nzp_mask, imm[7:0]}), 64'({1'b1, 3'b010, 8'h40}));
      instruction = mk(c_OP_CMP, 7'b111_0001, {7'd6, 7'd7, 5'd0}); in_pc = 8'h51;
      @(negedge clk);
      check("cmp", 64'({nzp_write, alu_op, reg_write, branch, nzp_mask}),
            64'({1'b1, c_ALU_SUB, 1'b0, 1'b0, 3'b000}));
      in_valid = 1'b0;
      @(negedge clk);

      // Mixed opcode stream with intermittent back-pressure.
      idx = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         out_ready = (cyc % 3) != 1;
         if (in_ready && idx < 9) begin
            in_valid = 1'b1; instruction = prog[idx]; in_pc = 8'(8'h60 + idx); idx++;
         end else if (in_ready) begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("stream_done", 64'(idx), 64'd9);

      // Reset while stalled with both entries full.
      out_ready = 1'b0; in_valid = 1'b1;
      instruction = mk(c_OP_LOAD, 7'd8, 19'h7654); in_pc = 8'h70;
      @(negedge clk);
      instruction = mk(c_OP_CONST, 7'd9, 19'h1234); in_pc = 8'h71;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_stall_state", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
      check("rst_stall_zero", 64'(dut_bundle), 64'd0);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);

      started = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
